// File: rtl/uart_pkg.sv
// UART shared definitions: RX frame states, parity encoding and parity helper.
// Latency: none (types and a pure function).
// Backpressure: not applicable.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b1;
  localparam logic PAR_ODD  = 1'b0;

  // Parity bit for a data word. Zero-extension does not change parity, so
  // callers of any width up to 32 bits pass their word widened to 32.
  function automatic logic calc_par(input logic [31:0] data, input logic par_type);
    return (par_type == PAR_EVEN) ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_rx_deser.sv
// RX deserializer: right-shifting register (first bit ends in bit 0) plus bit counter.
// Latency: data updates the cycle after shift_en; last_bit is combinational from the counter.
// Backpressure: none; shifts whenever shift_en is high.
module uart_rx_deser #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic                  clr,
  input  logic                  rx_bit,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last_bit
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [CW-1:0] cnt;

  // High while the shift being accepted is the final data bit of the frame.
  assign last_bit = (cnt == CW'(DATA_WIDTH - 1));

  // Shift new bits in at the MSB; counter wraps to zero after the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      data <= '0;
    end else if (clr) begin
      cnt  <= '0;
      data <= '0;
    end else if (shift_en) begin
      data <= {rx_bit, data[DATA_WIDTH-1:1]};
      cnt  <= last_bit ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART RX frame engine: walks start/data/parity/stop, checks parity and stop, emits bytes.
// Latency: outputs update the cycle after the stop-bit strobe.
// Backpressure: none; data_valid is a one-cycle pulse the consumer must take.
module uart_rx_frame_check
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sampled_bit,
  input  logic                  bit_strobe,
  input  logic                  par_en,
  input  logic                  par_type,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  rx_state_t             state;
  logic                  cfg_par_en;
  logic                  cfg_par_type;
  logic                  par_mis;
  logic                  start_det;
  logic                  shift_en;
  logic                  last_bit;
  logic [DATA_WIDTH-1:0] shift_data;

  assign start_det = (state == RX_IDLE) && bit_strobe && !sampled_bit;
  assign shift_en  = (state == RX_DATA) && bit_strobe;

  uart_rx_deser #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_deser (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .clr      (start_det),
    .rx_bit   (sampled_bit),
    .data     (shift_data),
    .last_bit (last_bit)
  );

  // Frame FSM with registered outputs; only strobe cycles move it forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RX_IDLE;
      cfg_par_en   <= 1'b0;
      cfg_par_type <= 1'b0;
      par_mis      <= 1'b0;
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      par_err      <= 1'b0;
      stp_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (bit_strobe) begin
        case (state)
          RX_IDLE: begin
            if (!sampled_bit) begin
              // Config is frozen here so mid-frame changes cannot corrupt the check.
              cfg_par_en   <= par_en;
              cfg_par_type <= par_type;
              par_mis      <= 1'b0;
              busy         <= 1'b1;
              state        <= RX_DATA;
            end
          end
          RX_DATA: begin
            if (last_bit) begin
              state <= cfg_par_en ? RX_PARITY : RX_STOP;
            end
          end
          RX_PARITY: begin
            par_mis <= (sampled_bit != calc_par(32'(shift_data), cfg_par_type));
            state   <= RX_STOP;
          end
          RX_STOP: begin
            stp_err <= !sampled_bit;
            par_err <= par_mis;
            if (sampled_bit && !par_mis) begin
              P_DATA     <= shift_data;
              data_valid <= 1'b1;
            end
            busy  <= 1'b0;
            state <= RX_IDLE;
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule
